stage_reg_em_hs: RTL and testbench
==================================

// Module: stage_reg_em_hs
// PURPOSE
//  Parametrised EX->MEM pipeline register with valid/ready handshake, stall hold and flush.
//  Sits between the EX stage (ALU, rt forward mux) and the MEM stage (DM, writeback select).
//  Carries IR, ALU result, store data, regdst, pc and pc8.
//  Bubbles are loaded as all-zero payload, so IR=0 reads as nop downstream.
// PARAMETERS
//  DATA_W    32  width of IR, ALU result and store data
//  PC_W      32  width of pc and pc8
//  REGDST_W  2   width of the regdst selector
// PORTS
//  clk         in   1         rising-edge clock
//  reset       in   1         asynchronous, active-high; clears all state
//  flush       in   1         synchronous kill of the held instruction(s); beats in_valid
//  in_valid    in   1         EX presents a valid instruction
//  in_ready    out  1         stage accepts the EX payload this cycle
//  IR_E        in   DATA_W    instruction word
//  ALU_C_E     in   DATA_W    ALU result / DM address
//  DM_Write_E  in   DATA_W    store data (forwarded rt)
//  regdst_E    in   REGDST_W  destination-register select
//  pc_E        in   PC_W      instruction pc
//  pc8_E       in   PC_W      link value pc+8
//  out_valid   out  1         MEM-side payload is valid
//  out_ready   in   1         MEM consumes the payload this cycle
//  IR_M, ALU_C_M, DM_Write_M, regdst_M, pc_M, pc8_M  out  (widths as the _E ports)  registered payload
// BEHAVIOUR
//  - Accept: in_valid & in_ready. Consume: out_valid & out_ready.
//  - Async reset: out_valid=0, every payload output=0, skid empty. in_ready=1 once reset deasserts.
//  - Latency: 1 cycle from accept to out_valid, with payload unchanged bit-for-bit.
//  - Base mode: in_ready = !out_valid | out_ready (combinational).
//    Posedge with in_ready=1: out_valid<=in_valid; payload<=in_valid ? _E : 0.
//    Posedge with in_ready=0: hold out_valid and payload (stall).
//  - flush=1 at posedge: out_valid<=0 and payload<=0, whatever the handshake inputs.
//    The accept in that cycle is discarded (in_ready is still reported).
//  - Payload of a held entry never changes while out_valid=1 & out_ready=0.
//  - States: EMPTY (out_valid=0), FULL (out_valid=1); SKID (skid_valid=1) exists only with the macro.
//    EMPTY->FULL on accept. FULL->EMPTY on consume without accept. FULL->FULL on consume+accept.
//    Any state -> EMPTY on flush.
//  - Reset mid-stall drops the instruction: no partial payload survives.
// CONFIGURATION
//  STAGE_EM_SKID_EN defined: adds a 1-entry skid buffer, and in_ready becomes a register.
//    in_ready = !skid_valid (no combinational path from out_ready).
//    Accept while FULL & !out_ready: the entry goes to skid; in_ready drops to 0 next cycle.
//    Consume while SKID: skid moves to the output regs; skid_valid<=0.
//    A new accept in the same cycle is impossible, because in_ready=0.
//    Order is preserved: skid data always follows the current output entry.
//    flush clears both output and skid. Reset clears the skid (skid_valid=0, data=0).
//  Not defined: base mode only; there is no skid storage or logic.
// TESTING
//  1 Reset asserted mid-cycle with out_valid=1 -> all outputs 0 immediately (async); in_ready=1 after release.
//  2 Stream IR 0x00221820..+3, out_ready=1 -> each appears 1 cycle later; out_valid stays 1; pc8_M=pc_M+8.
//  3 Accept IR=0x8C430004, then out_ready=0 for 3 cycles -> IR_M and ALU_C_M hold.
//    Base: in_ready=0. SKID_EN: one more accept lands in skid, then in_ready=0.
//  4 flush=1 together with in_valid=1, IR_E=0xAC450008 -> next cycle out_valid=0, IR_M=0; skid empty.
//  5 SKID_EN: fill output+skid with A,B; out_ready=1 for 2 cycles -> A then B, in order; in_ready returns to 1.
//  6 Random in_valid/out_ready/flush for 10k cycles -> scoreboard: no loss, duplication or reordering beyond flushes.

Source files
------------

// File: rtl/stage_reg_em_hs.sv
// EX->MEM pipeline register with valid/ready handshake, stall hold and synchronous flush.
// Define STAGE_EM_SKID_EN to add a 1-entry skid buffer and a registered in_ready.
module stage_reg_em_hs #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned PC_W     = 32,
    parameter int unsigned REGDST_W = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   IR_E,
    input  logic [DATA_W-1:0]   ALU_C_E,
    input  logic [DATA_W-1:0]   DM_Write_E,
    input  logic [REGDST_W-1:0] regdst_E,
    input  logic [PC_W-1:0]     pc_E,
    input  logic [PC_W-1:0]     pc8_E,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   IR_M,
    output logic [DATA_W-1:0]   ALU_C_M,
    output logic [DATA_W-1:0]   DM_Write_M,
    output logic [REGDST_W-1:0] regdst_M,
    output logic [PC_W-1:0]     pc_M,
    output logic [PC_W-1:0]     pc8_M
);

    localparam int unsigned PAY_W = 3 * DATA_W + REGDST_W + 2 * PC_W;

    logic [PAY_W-1:0] w_pay_e;
    logic [PAY_W-1:0] r_pay_m;
    logic             r_out_valid;

    assign w_pay_e   = {IR_E, ALU_C_E, DM_Write_E, regdst_E, pc_E, pc8_E};
    assign {IR_M, ALU_C_M, DM_Write_M, regdst_M, pc_M, pc8_M} = r_pay_m;
    assign out_valid = r_out_valid;

`ifdef STAGE_EM_SKID_EN
    logic             r_skid_valid;
    logic [PAY_W-1:0] r_skid_pay;

    // Ready depends only on skid occupancy, so no path from out_ready.
    assign in_ready = !r_skid_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_pay_m      <= '0;
            r_skid_valid <= 1'b0;
            r_skid_pay   <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_pay_m      <= '0;
            r_skid_valid <= 1'b0;
            r_skid_pay   <= '0;
        end else if (r_skid_valid) begin
            // Skid entry always follows the output entry; no accept possible here.
            if (out_ready) begin
                r_out_valid  <= 1'b1;
                r_pay_m      <= r_skid_pay;
                r_skid_valid <= 1'b0;
                r_skid_pay   <= '0;
            end
        end else if (!r_out_valid || out_ready) begin
            r_out_valid <= in_valid;
            r_pay_m     <= in_valid ? w_pay_e : '0;
        end else if (in_valid) begin
            r_skid_valid <= 1'b1;
            r_skid_pay   <= w_pay_e;
        end
    end
`else
    assign in_ready = !r_out_valid || out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_pay_m     <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_pay_m     <= '0;
        end else if (in_ready) begin
            // Bubbles load an all-zero payload so IR_M reads as nop.
            r_out_valid <= in_valid;
            r_pay_m     <= in_valid ? w_pay_e : '0;
        end
    end
`endif

endmodule

// File: tb/tb_stage_reg_em_hs.sv
// Randomised bench for stage_reg_em_hs against an in-order FIFO reference model.
// Follows STAGE_EM_SKID_EN so the model capacity matches the build.
module tb_stage_reg_em_hs;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned PC_W     = 32;
    localparam int unsigned REGDST_W = 2;
    localparam int unsigned PAY_W    = 3 * DATA_W + REGDST_W + 2 * PC_W;
`ifdef STAGE_EM_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready;
    logic out_valid;
    logic [PAY_W-1:0] r_pe = '0;

    logic [DATA_W-1:0]   IR_E, ALU_C_E, DM_Write_E, IR_M, ALU_C_M, DM_Write_M;
    logic [REGDST_W-1:0] regdst_E, regdst_M;
    logic [PC_W-1:0]     pc_E, pc8_E, pc_M, pc8_M;
    logic [PAY_W-1:0]    w_pm;

    assign {IR_E, ALU_C_E, DM_Write_E, regdst_E, pc_E, pc8_E} = r_pe;
    assign w_pm = {IR_M, ALU_C_M, DM_Write_M, regdst_M, pc_M, pc8_M};

    always #5 clk = ~clk;

    stage_reg_em_hs #(.DATA_W(DATA_W), .PC_W(PC_W), .REGDST_W(REGDST_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .IR_E       (IR_E),
        .ALU_C_E    (ALU_C_E),
        .DM_Write_E (DM_Write_E),
        .regdst_E   (regdst_E),
        .pc_E       (pc_E),
        .pc8_E      (pc8_E),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .IR_M       (IR_M),
        .ALU_C_M    (ALU_C_M),
        .DM_Write_M (DM_Write_M),
        .regdst_M   (regdst_M),
        .pc_M       (pc_M),
        .pc8_M      (pc8_M)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [PAY_W-1:0] q[$];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PAY_W-1:0] mk_pay(input logic [31:0] ir, input logic [31:0] pc);
        logic [31:0] alu;
        logic [31:0] dm;
        logic [1:0]  rd;
        alu = $urandom;
        dm  = $urandom;
        rd  = 2'($urandom_range(0, 3));
        return {ir, alu, dm, rd, pc, pc + 32'd8};
    endfunction

    // One clock of stimulus; the queue holds every instruction the stage owes MEM, oldest first.
    task automatic step(input logic fl, input logic iv, input logic orr, input logic [PAY_W-1:0] p);
        logic exp_rdy;
        flush     = fl;
        in_valid  = iv;
        out_ready = orr;
        r_pe      = p;
        #1;
        exp_rdy = (CAP == 2) ? (q.size() < 2) : (q.size() == 0 || orr);
        check("in_ready", 256'(in_ready), 256'(exp_rdy));
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (q.size() > 0 && orr) void'(q.pop_front());
            if (iv && exp_rdy) q.push_back(p);
        end
        #1;
        check("out_valid", 256'(out_valid), 256'(q.size() > 0));
        check("payload", 256'(w_pm), (q.size() > 0) ? 256'(q[0]) : 256'(0));
    endtask

    logic [PAY_W-1:0] pa, pb;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_payload", 256'(w_pm), 256'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_in_ready", 256'(in_ready), 256'(1));

        // Stream of four instructions with MEM always ready
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b1, mk_pay(32'h00221820 + i, 32'h0040_0000 + 4 * i));
            check("stream_ir", 256'(IR_M), 256'(32'h00221820 + i));
            check("stream_pc8", 256'(pc8_M), 256'(32'h0040_0008 + 4 * i));
        end
        step(1'b0, 1'b0, 1'b1, '0);

        // Stall: output holds while MEM is not ready
        pa = mk_pay(32'h8C430004, 32'h0040_0100);
        step(1'b0, 1'b1, 1'b1, pa);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, mk_pay(32'h1000_0000 + i, 32'h0040_0200));
            check("stall_ir", 256'(IR_M), 256'(32'h8C430004));
            check("stall_alu", 256'(ALU_C_M), 256'(pa[PAY_W-DATA_W-1 -: DATA_W]));
        end
        check("stall_in_ready", 256'(in_ready), 256'(0));

        // Flush beats an accompanying valid
        step(1'b1, 1'b1, 1'b0, mk_pay(32'hAC450008, 32'h0040_0300));
        check("flush_valid", 256'(out_valid), 256'(0));
        check("flush_ir", 256'(IR_M), 256'(0));

`ifdef STAGE_EM_SKID_EN
        // Output + skid drain in order
        pa = mk_pay(32'hA000_0001, 32'h0040_0400);
        pb = mk_pay(32'hB000_0002, 32'h0040_0404);
        step(1'b0, 1'b1, 1'b0, pa);
        step(1'b0, 1'b1, 1'b0, pb);
        check("skid_full_ready", 256'(in_ready), 256'(0));
        step(1'b0, 1'b0, 1'b1, '0);
        check("skid_first", 256'(w_pm), 256'(pb));
        step(1'b0, 1'b0, 1'b1, '0);
        check("skid_drained", 256'(out_valid), 256'(0));
        check("skid_ready_back", 256'(in_ready), 256'(1));
`else
        pa = mk_pay(32'hA000_0001, 32'h0040_0400);
        step(1'b0, 1'b1, 1'b0, pa);
        check("base_hold_ir", 256'(IR_M), 256'(32'hA000_0001));
        step(1'b0, 1'b0, 1'b1, '0);
`endif

        // Async reset mid-stall drops the held instruction immediately
        step(1'b0, 1'b1, 1'b0, mk_pay(32'h0000_BEEF, 32'h0040_0500));
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", 256'(out_valid), 256'(0));
        check("async_rst_payload", 256'(w_pm), 256'(0));
        #1;
        reset     = 1'b0;
        out_ready = 1'b0;
        q.delete();
        #1;
        check("async_rst_ready", 256'(in_ready), 256'(1));

        // Random traffic against the FIFO model
        for (int i = 0; i < 10000; i++) begin
            step(($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 70),
                 ($urandom_range(0, 99) < 60), mk_pay($urandom, $urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
